// File: rtl/ysyx_25070198_ifu_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25070198_ifu_fifo_if
// Brief    : Instruction-fetch bus (request/response) handshake bundle.
// Revision : 1.0
// ============================================================================
interface ysyx_25070198_ifu_fifo_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25070198_ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25070198_ifu_fifo
// Brief    : Fetch unit with one outstanding bus request and a small
//            registered instruction buffer, flushed on redirect.
// Revision : 1.0
// ============================================================================
module ysyx_25070198_ifu_fifo #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  wire                              clk,
  input  wire                              rst,
  input  wire                              redirect,
  input  wire  [31:0]                      redirect_pc,
  ysyx_25070198_ifu_fifo_if.master         bus,
  output logic                             out_valid,
  input  wire                              out_ready,
  output logic [31:0]                      out_pc,
  output logic [31:0]                      out_inst,
  output logic                             out_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  localparam logic [1:0] C_ST_REQ   = 2'd0;
  localparam logic [1:0] C_ST_WAIT  = 2'd1;
  localparam logic [1:0] C_ST_FLUSH = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic          r_mem_err  [DEPTH];

  logic        w_req_hs;
  logic        w_resp_hs;
  logic        w_push;
  logic        w_pop;
  logic        w_not_full;
  logic [31:0] w_redirect_tgt;

  assign w_not_full     = (r_count < C_DEPTH);
  assign w_req_hs       = bus.req_valid && bus.req_ready;
  assign w_resp_hs      = bus.resp_valid && bus.resp_ready;
  assign w_pop          = out_valid && out_ready;
  assign w_push         = w_resp_hs && (r_state == C_ST_WAIT) && !redirect;
  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_REQ: begin
        if (w_req_hs) begin
          w_state_nxt = redirect ? C_ST_FLUSH : C_ST_WAIT;
        end
      end
      C_ST_WAIT: begin
        // A response coinciding with redirect is dropped but still retires the request.
        if (w_resp_hs) begin
          w_state_nxt = C_ST_REQ;
        end else if (redirect) begin
          w_state_nxt = C_ST_FLUSH;
        end
      end
      C_ST_FLUSH: begin
        if (w_resp_hs) begin
          w_state_nxt = C_ST_REQ;
        end
      end
      default: w_state_nxt = C_ST_REQ;
    endcase
  end

  // Outputs are gated by rst so they drop to zero as soon as reset asserts.
  always_comb begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    if (rst) begin
      case (r_state)
        C_ST_REQ: begin
          bus.req_valid = w_not_full;
          bus.req_addr  = r_fetch_pc;
        end
        C_ST_WAIT, C_ST_FLUSH: bus.resp_ready = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_req_hs) begin
        r_req_pc <= r_fetch_pc;
      end
      if (redirect) begin
        r_fetch_pc <= w_redirect_tgt;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_req_hs) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_req_pc;
      r_mem_inst[r_wr_ptr] <= bus.resp_data;
      r_mem_err[r_wr_ptr]  <= bus.resp_err;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]   : '0;
  assign out_inst  = out_valid ? r_mem_inst[r_rd_ptr] : '0;
  assign out_err   = out_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

endmodule
`default_nettype wire

// File: doc/ysyx_25070198_ifu_fifo.md
YSYX_25070198_IFU_FIFO -- requirements
Module: ysyx_25070198_ifu_fifo

Interface
REQ-001 Parameter RESET_PC, default 32'h80000000, SHALL set the fetch address after reset.
REQ-002 Parameter DEPTH, default 4, SHALL set the instruction-buffer entry count; legal values are powers of two from 2 to 16.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-low (asserted when 0).
REQ-005 redirect  in  1  SHALL request a fetch-stream redirect (jump or branch taken).
REQ-006 redirect_pc  in  32  SHALL give the new fetch address.
REQ-007 req_valid  out  1  SHALL flag a valid fetch request on the bus.
REQ-008 req_ready  in  1  SHALL flag that the bus accepts the request.
REQ-009 req_addr  out  32  SHALL carry the fetch address.
REQ-010 resp_valid  in  1  SHALL flag returned instruction data.
REQ-011 resp_ready  out  1  SHALL flag that the block accepts the response.
REQ-012 resp_data  in  32  SHALL carry the instruction word.
REQ-013 resp_err  in  1  SHALL flag an access fault for the response.
REQ-014 out_valid  out  1  SHALL flag a valid instruction to decode.
REQ-015 out_ready  in  1  SHALL flag that decode consumes the instruction.
REQ-016 out_pc / out_inst / out_err  out  32/32/1  SHALL carry the head entry's PC, word and fault flag.

Function
REQ-017 States SHALL be REQ, WAIT and FLUSH; at most one bus request is outstanding.
REQ-018 In REQ, req_valid SHALL be 1 iff count < DEPTH, and req_addr SHALL equal fetch_pc.
REQ-019 req_valid and req_addr SHALL hold stable while req_valid=1 and req_ready=0, unless redirect is asserted.
REQ-020 On a request handshake, fetch_pc SHALL advance by 4 (mod 2^32) and the state SHALL go to WAIT.
REQ-021 In WAIT and FLUSH, resp_ready SHALL be 1; in REQ it SHALL be 0.
REQ-022 On a response handshake in WAIT, {request PC, resp_data, resp_err} SHALL be pushed and the state SHALL return to REQ; the earliest next request is the following cycle.
REQ-023 On a response handshake in FLUSH, the response SHALL be discarded and the state SHALL go to REQ.
REQ-024 The buffer SHALL be a circular FIFO with pointers wrapping modulo DEPTH and a count of width log2(DEPTH)+1; the invariant count + outstanding <= DEPTH SHALL guarantee that a response always has a slot.
REQ-025 out_valid SHALL be 1 iff count != 0; out_* SHALL show the head entry; out_pc, out_inst and out_err SHALL be 0 when out_valid=0.
REQ-026 A pop SHALL occur on out_valid && out_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-027 Minimum latency from response handshake to out_valid SHALL be 1 cycle; the buffer is registered with no bypass.
REQ-028 When redirect=1: FIFO count SHALL be 0 the next cycle; fetch_pc SHALL become {redirect_pc[31:2], 2'b00}; redirect SHALL take priority over push, pop and PC increment.
REQ-029 A consumer handshake in the redirect cycle SHALL count as accepted.
REQ-030 Redirect in REQ without a request handshake SHALL stay in REQ; the next request SHALL use the new PC.
REQ-031 Redirect in REQ with a request handshake in the same cycle SHALL go to FLUSH.
REQ-032 Redirect in WAIT without a response SHALL go to FLUSH; with a response in the same cycle, the response SHALL be dropped and the state SHALL go to REQ.
REQ-033 Redirect in FLUSH SHALL update fetch_pc and keep the state's normal FLUSH transition.

Reset
REQ-034 While rst=0: state=REQ, fetch_pc=RESET_PC, count=0, pointers=0, req_valid=0, resp_ready=0, out_valid=0, out_pc/out_inst/out_err=0; buffer storage is not reset.
REQ-035 Reset mid-transaction SHALL drop any outstanding request; the bus interconnect SHALL be reset by the same rst.
REQ-036 req_valid SHALL first assert in the first cycle after rst deasserts.

Verification
REQ-037 Scenario: reset release, bus always ready, 1-cycle response -> req_addr 0x80000000, 0x80000004, 0x80000008 on every second cycle; out_pc follows in order with matching resp_data.
REQ-038 Scenario: out_ready=0 with DEPTH=4 -> exactly 4 responses buffered, then req_valid=0; one pop -> req_valid reasserts with the next address.
REQ-039 Scenario: redirect to 0x80001002 while in WAIT -> the in-flight response is discarded, out_valid=0 next cycle, next req_addr=0x80001000.
REQ-040 Scenario: redirect in the same cycle as a response handshake, and separately in the same cycle as a request handshake -> no stale entry reaches out_*; next request address is the redirect target.
REQ-041 Scenario: resp_err=1 on the 2nd fetch -> out_err=1 only with out_pc=0x80000004.
REQ-042 Scenario: rst pulsed low during WAIT -> all outputs 0 asynchronously; after release, req_addr=0x80000000.
